// File: rtl/flash_programmer.sv
// Word-program / block-erase sequencer for Intel/Micron-style parallel NOR flash.
// Issues the command writes, polls the status register and always exits via read-array (0xFF).
module flash_programmer #(
  parameter bit          REVERSE    = 1'b1,
  parameter int unsigned WE_CYCLES  = 2,
  parameter int unsigned POLL_LIMIT = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic        cmd_erase,
  input  logic [21:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  status,
  output logic        flash_ce,
  output logic        flash_rp,
  output logic        flash_byte,
  output logic        flash_vpen,
  output logic        flash_we,
  output logic        flash_oe,
  output logic [21:0] flash_addr,
  inout  wire  [15:0] flash_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_SAMPLE, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    W_CMD, W_DATA, W_CLR, W_RESTORE
  } wsel_e;

  localparam logic [3:0]  WE_LAST   = 4'(WE_CYCLES - 1);
  localparam logic [23:0] LIMIT     = 24'(POLL_LIMIT);

  state_e      state_q, state_d;
  wsel_e       wsel_q, wsel_d;
  logic [3:0]  tmr_q, tmr_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [21:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        erase_q, erase_d;
  logic [7:0]  status_q, status_d;
  logic        error_q, error_d;

  logic [23:0] cnt_inc;
  logic        sr_err;
  logic        drive;
  logic [15:0] wr_data;
  logic        unused_hi;

  assign cnt_inc   = cnt_q + 24'd1;
  assign sr_err    = sr_q[5] | sr_q[4] | sr_q[3] | sr_q[1];
  assign unused_hi = ^flash_data[15:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wsel_q   <= W_CMD;
      tmr_q    <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      erase_q  <= 1'b0;
      status_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wsel_q   <= wsel_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      erase_q  <= erase_d;
      status_q <= status_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wsel_d   = wsel_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    erase_d  = erase_q;
    status_d = status_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = addr;
          wdata_d = wdata;
          erase_d = cmd_erase;
          error_d = 1'b0;
          cnt_d   = '0;
          wsel_d  = W_CMD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        tmr_d   = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (tmr_q == WE_LAST) state_d = S_HOLD;
        else                  tmr_d   = tmr_q + 4'd1;
      end
      S_HOLD: begin
        case (wsel_q)
          W_CMD:     begin wsel_d = W_DATA;    state_d = S_SETUP; end
          W_DATA:    begin tmr_d  = '0;        state_d = S_WAIT;  end
          W_CLR:     begin wsel_d = W_RESTORE; state_d = S_SETUP; end
          W_RESTORE: state_d = S_DONE;
        endcase
      end
      // SR is latched on the edge that closes the second OE-low cycle, while the device still drives.
      S_WAIT: begin
        if (tmr_q == 4'd1) begin
          sr_d    = flash_data[7:0];
          state_d = S_SAMPLE;
        end else begin
          tmr_d = tmr_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        cnt_d = cnt_inc;
        if (sr_q[7]) begin
          status_d = sr_q;
          error_d  = sr_err;
          wsel_d   = sr_err ? W_CLR : W_RESTORE;
          state_d  = S_SETUP;
        end else if (cnt_inc >= LIMIT) begin
          status_d = '0;
          error_d  = 1'b1;
          wsel_d   = W_RESTORE;
          state_d  = S_SETUP;
        end else begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    error      = error_q;
    status     = status_q;
    flash_ce   = 1'b0;
    flash_rp   = 1'b1;
    flash_byte = 1'b1;
    flash_vpen = 1'b1;
    flash_we   = (state_q != S_PULSE);
    flash_oe   = (state_q != S_WAIT);
    flash_addr = addr_q;
    drive      = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);
    wr_data    = 16'h00FF;
    case (wsel_q)
      W_CMD:     wr_data = erase_q ? 16'h0020 : 16'h0040;
      W_DATA: begin
        if (erase_q)      wr_data = 16'h00D0;
        else if (REVERSE) wr_data = {wdata_q[7:0], wdata_q[15:8]};
        else              wr_data = wdata_q;
      end
      W_CLR:     wr_data = 16'h0050;
      W_RESTORE: wr_data = 16'h00FF;
    endcase
  end

  assign flash_data = drive ? wr_data : 'z;

endmodule
